// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage constants: bubble encoding, reset PC and fetch FSM state encodings.
package instruction_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] PC_STEP           = 32'h0000_0004;
  localparam logic [31:0] WORD_ALIGN_MASK   = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_ifid_pipeline_register.sv
// IF/ID pipeline register: instruction, PC and valid bit with load, bubble and hold controls.
module ifid_pipeline_register
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  // Bubble beats load; with neither asserted the register holds.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (bubble) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = instr_in;
      pc_d    = pc_in;
      valid_d = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      instr_q <= NOP_INSTR;
      pc_q    <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_out = instr_q;
  assign pc_out    = pc_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: PC, BUSYWAIT fetch handshake, stall hold buffer and redirect draining of in-flight accesses.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET_N,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDRESS,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] IFID_INSTRUCTION,
  output logic [31:0] IFID_PC,
  output logic        IFID_VALID
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_instr_q, hold_instr_d;
  logic [31:0]  hold_pc_q, hold_pc_d;
  logic [31:0]  pending_pc_q, pending_pc_d;

  logic         ifid_load;
  logic         ifid_bubble;
  logic [31:0]  ifid_instr_in;
  logic [31:0]  ifid_pc_in;
  logic [31:0]  target_aligned;

  assign target_aligned = BRANCH_TARGET & WORD_ALIGN_MASK;
  assign IMEM_READ      = RESET_N && (state_q != HOLD);
  assign IMEM_ADDRESS   = pc_q;

  // Next-state logic: redirect first, then per-state handling of busywait and stall.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    pending_pc_d  = pending_pc_q;
    ifid_load     = 1'b0;
    ifid_bubble   = 1'b0;
    ifid_instr_in = IMEM_READDATA;
    ifid_pc_in    = pc_q;

    if (BRANCH_TAKEN) begin
      ifid_bubble  = 1'b1;
      hold_instr_d = NOP_INSTR;
      hold_pc_d    = 32'h0000_0000;
      // A pending memory access must complete at the old address before jumping.
      if ((state_q != HOLD) && IMEM_BUSYWAIT) begin
        pending_pc_d = target_aligned;
        state_d      = DRAIN;
      end else begin
        pc_d    = target_aligned;
        state_d = FETCH;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (!IMEM_BUSYWAIT) begin
            pc_d = pc_q + PC_STEP;
            if (STALL) begin
              hold_instr_d = IMEM_READDATA;
              hold_pc_d    = pc_q;
              state_d      = HOLD;
            end else begin
              ifid_load = 1'b1;
            end
          end else if (!STALL) begin
            ifid_bubble = 1'b1;
          end else begin
            ifid_bubble = 1'b0;
          end
        end
        HOLD: begin
          if (!STALL) begin
            ifid_load     = 1'b1;
            ifid_instr_in = hold_instr_q;
            ifid_pc_in    = hold_pc_q;
            state_d       = FETCH;
          end else begin
            state_d = HOLD;
          end
        end
        DRAIN: begin
          if (!IMEM_BUSYWAIT) begin
            pc_d    = pending_pc_q;
            state_d = FETCH;
          end else begin
            state_d = DRAIN;
          end
          ifid_bubble = !STALL;
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= 32'h0000_0000;
      pending_pc_q <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      pending_pc_q <= pending_pc_d;
    end
  end

  ifid_pipeline_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk       (CLK),
    .reset_n   (RESET_N),
    .load      (ifid_load),
    .bubble    (ifid_bubble),
    .instr_in  (ifid_instr_in),
    .pc_in     (ifid_pc_in),
    .instr_out (IFID_INSTRUCTION),
    .pc_out    (IFID_PC),
    .valid_out (IFID_VALID)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: per-cycle stimulus with a queue of expected IF/ID contents.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_readdata;
  logic        imem_busywait = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0000_0000;
  logic [31:0] ifid_instruction;
  logic [31:0] ifid_pc;
  logic        ifid_valid;

  int n_checks = 0;
  int n_errors = 0;
  logic [64:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16] ^ a[15:0] ^ 16'h0F0F};
  endfunction

  assign imem_readdata = imem_read ? mem_word(imem_address) : 32'hDEAD_BEEF;

  instruction_fetch_unit dut (
    .CLK              (clk),
    .RESET_N          (reset_n),
    .IMEM_READ        (imem_read),
    .IMEM_ADDRESS     (imem_address),
    .IMEM_READDATA    (imem_readdata),
    .IMEM_BUSYWAIT    (imem_busywait),
    .STALL            (stall),
    .BRANCH_TAKEN     (branch_taken),
    .BRANCH_TARGET    (branch_target),
    .IFID_INSTRUCTION (ifid_instruction),
    .IFID_PC          (ifid_pc),
    .IFID_VALID       (ifid_valid)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check IMEM side, queue the IF/ID expectation, check it after the edge.
  task automatic cyc(input logic rst, input logic busy, input logic stl, input logic br,
                     input logic [31:0] tgt, input logic exp_read, input logic [31:0] exp_addr,
                     input logic [31:0] exp_pc, input logic exp_valid, input string tag);
    logic [64:0] e;
    @(negedge clk);
    reset_n       = rst;
    imem_busywait = busy;
    stall         = stl;
    branch_taken  = br;
    branch_target = tgt;
    #1;
    check_value({tag, ".read"}, {31'd0, imem_read}, {31'd0, exp_read});
    if (rst) check_value({tag, ".addr"}, imem_address, exp_addr);
    exp_q.push_back({exp_valid ? mem_word(exp_pc) : NOP, exp_pc, exp_valid});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_value({tag, ".instr"}, ifid_instruction, e[64:33]);
    check_value({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, e[0]});
    if (e[0] || !rst) check_value({tag, ".pc"}, ifid_pc, e[32:1]);
  endtask

  initial begin
    // Reset then sequential hits
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, "rst0");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, "rst1");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0,  32'h0,  1'b1, "hit0");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4,  32'h4,  1'b1, "hit4");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8,  32'h8,  1'b1, "hit8");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC,  32'hC,  1'b1, "hitC");
    // Three-cycle miss at 0x10
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 32'h0, 1'b0, "miss");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 32'h10, 1'b1, "miss_done");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h14, 32'h14, 1'b1, "hit14");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h18, 32'h18, 1'b1, "hit18");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1C, 32'h1C, 1'b1, "hit1C");
    // Stall on hit of 0x20: IF/ID keeps 0x1C, then releases 0x20 exactly once
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 32'h1C, 1'b1, "stall_a");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h24, 32'h1C, 1'b1, "stall_b");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h24, 32'h20, 1'b1, "release");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h24, 32'h24, 1'b1, "hit24");
    // Redirect with misaligned target overriding stall
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h103, 1'b1, 32'h28, 32'h0, 1'b0, "br_hit");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 32'h100, 1'b1, "hit100");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h40,  1'b1, 32'h104, 32'h0, 1'b0, "br40");
    // Redirect during miss: drain 0x40, second redirect wins
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h40, 32'h0, 1'b0, "miss40");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 32'h40, 32'h0, 1'b0, "br200");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h40, 32'h0, 1'b0, "drain_a");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h300, 1'b1, 32'h40, 32'h0, 1'b0, "br300");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h40, 32'h0, 1'b0, "drain_end");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h300, 32'h300, 1'b1, "hit300");
    // PC wrap
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h304, 32'h0, 1'b0, "br_top");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, "hit_top");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b1, "wrap");
    // Reset while draining
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h500, 1'b1, 32'h4, 32'h0, 1'b0, "br500");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 32'h0, 1'b0, "rst_drain");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0, 32'h0, 1'b1, "post_rst0");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4, 32'h4, 1'b1, "post_rst4");
    // Redirect while holding: buffered word 0x8 is discarded
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8, 32'h4, 1'b1, "hold8");
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h600, 1'b0, 32'hC, 32'h0, 1'b0, "br_hold");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h600, 32'h600, 1'b1, "hit600");
    // Miss with stall holds IF/ID
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h604, 32'h600, 1'b1, "miss_stall");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h604, 32'h604, 1'b1, "hit604");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
